// File: rtl/jpc_imem_responder_pkg.sv
// jpc_imem_responder_pkg
// Shared constants and types for the instruction-memory responder:
// address/instruction widths, fault codes returned to fetch, the FSM state
// encoding and the address classification helper used by both the request
// path and the preload path.
package jpc_imem_responder_pkg;

    localparam int JPC_ADDRESS_WIDTH = 32;
    localparam int JPC_INSTR_WIDTH   = 32;
    localparam int WAIT_CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        IMEM_FAULT_NONE     = 2'b00,
        IMEM_FAULT_MISALIGN = 2'b01,
        IMEM_FAULT_RANGE    = 2'b10
    } imem_fault_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } imem_state_e;

    // Misalignment is reported in preference to out-of-range. The lower-bound
    // test runs before the subtract so an address below the base can never
    // wrap around into a legal word index.
    function automatic imem_fault_e classify_addr(
        input logic [JPC_ADDRESS_WIDTH-1:0] addr,
        input logic [JPC_ADDRESS_WIDTH-1:0] base,
        input logic [JPC_ADDRESS_WIDTH-1:0] depth
    );
        if (addr[1:0] != 2'b00) begin
            return IMEM_FAULT_MISALIGN;
        end
        if (addr < base) begin
            return IMEM_FAULT_RANGE;
        end
        if (((addr - base) >> 2) >= depth) begin
            return IMEM_FAULT_RANGE;
        end
        return IMEM_FAULT_NONE;
    endfunction

endpackage

// File: rtl/jpc_imem_responder_bram.sv
// jpc_32bram
// Single-port 32-bit wide block RAM with a registered read and a shared
// read/write address.
// Ports:
//   clk    clock, rising edge
//   we     write enable, stores wdata at addr
//   en     read enable, registers mem[addr] into rdata
//   addr   word address
//   wdata  write data
//   rdata  registered read data; holds its value while en is low
module jpc_32bram
    import jpc_imem_responder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic                       en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [JPC_INSTR_WIDTH-1:0] wdata,
    output logic [JPC_INSTR_WIDTH-1:0] rdata
);

    logic [JPC_INSTR_WIDTH-1:0] mem [0:DEPTH-1];

    // Read output only updates on an enabled read, so the responder can rely
    // on it staying put for as long as a response is outstanding.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/jpc_imem_responder.sv
// jpc_imem_responder
// Memory-side responder for instruction fetch. Accepts word reads over a
// valid/ready request channel, reads a jpc_32bram, and returns data plus a
// fault code over a valid/ready response channel after a configurable number
// of wait states. A load port preloads program words while the block is idle.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   req_valid_I/req_ready_O/req_addr_I fetch request channel (byte address)
//   flush_I                           abandon any in-flight request/response
//   rsp_valid_O/rsp_ready_I           response handshake
//   rsp_data_O/rsp_fault_O            instruction word (0 on fault) and fault code
//   load_we_I/load_addr_I/load_data_I preload write port, honoured only in IDLE
//   busy_O                            high whenever the FSM is not IDLE
module jpc_imem_responder
    import jpc_imem_responder_pkg::*;
#(
    parameter int                            DEPTH       = 256,
    parameter int                            WAIT_STATES = 1,
    parameter logic [JPC_ADDRESS_WIDTH-1:0]  BASE_ADDR   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_I,
    output logic                         req_ready_O,
    input  logic [JPC_ADDRESS_WIDTH-1:0] req_addr_I,
    input  logic                         flush_I,
    output logic                         rsp_valid_O,
    input  logic                         rsp_ready_I,
    output logic [JPC_INSTR_WIDTH-1:0]   rsp_data_O,
    output logic [1:0]                   rsp_fault_O,
    input  logic                         load_we_I,
    input  logic [JPC_ADDRESS_WIDTH-1:0] load_addr_I,
    input  logic [JPC_INSTR_WIDTH-1:0]   load_data_I,
    output logic                         busy_O
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [JPC_ADDRESS_WIDTH-1:0] DEPTH_A = JPC_ADDRESS_WIDTH'(DEPTH);

    imem_state_e                state, state_next;
    imem_fault_e                req_fault, load_fault, rsp_fault;
    logic [IDX_W-1:0]           req_index, load_index, bram_addr;
    logic [JPC_INSTR_WIDTH-1:0] bram_rdata, rsp_data;
    logic [WAIT_CNT_WIDTH-1:0]  wait_cnt;
    logic                       accept, bram_we, bram_rd;

    assign req_fault  = classify_addr(req_addr_I, BASE_ADDR, DEPTH_A);
    assign load_fault = classify_addr(load_addr_I, BASE_ADDR, DEPTH_A);
    assign req_index  = IDX_W'((req_addr_I - BASE_ADDR) >> 2);
    assign load_index = IDX_W'((load_addr_I - BASE_ADDR) >> 2);

    assign req_ready_O = (state == ST_IDLE) & ~flush_I & ~load_we_I & ~rst;
    assign accept      = req_valid_I & req_ready_O;

    // Loads and requests never coincide because req_ready_O is masked by
    // load_we_I, so one shared address port is enough.
    assign bram_we   = (state == ST_IDLE) & load_we_I & ~rst & (load_fault == IMEM_FAULT_NONE);
    assign bram_rd   = accept & (req_fault == IMEM_FAULT_NONE);
    assign bram_addr = load_we_I ? load_index : req_index;

    // With no wait states the READ cycle itself presents the response,
    // taking data straight from the RAM output, which is stable because the
    // RAM is only read on an accept.
    assign rsp_valid_O = (state == ST_RESP) | ((WAIT_STATES == 0) & (state == ST_READ));
    assign rsp_data_O  = ((WAIT_STATES == 0) && (state == ST_READ)) ? bram_rdata : rsp_data;
    assign rsp_fault_O = rsp_fault;
    assign busy_O      = (state != ST_IDLE);

    jpc_32bram #(
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_bram (
        .clk   (clk),
        .we    (bram_we),
        .en    (bram_rd),
        .addr  (bram_addr),
        .wdata (load_data_I),
        .rdata (bram_rdata)
    );

    // Next-state logic. READ is the cycle in which RAM data is available, so
    // the response appears WAIT_STATES cycles after it; WAIT therefore only
    // exists for two or more wait states and covers WAIT_STATES-1 cycles.
    // Flush overrides everything outside IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (req_fault == IMEM_FAULT_NONE) ? ST_READ : ST_RESP;
                end
            end
            ST_READ: begin
                if (WAIT_STATES == 0) begin
                    state_next = rsp_ready_I ? ST_IDLE : ST_RESP;
                end else if (WAIT_STATES == 1) begin
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_I) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush_I && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // State register plus the response and wait-counter registers. A faulted
    // request loads a zero data word at accept and never touches the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_data  <= '0;
            rsp_fault <= IMEM_FAULT_NONE;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_fault <= req_fault;
                        rsp_data  <= '0;
                    end
                end
                ST_READ: begin
                    rsp_data <= bram_rdata;
                    if (WAIT_STATES >= 2) begin
                        wait_cnt <= WAIT_CNT_WIDTH'(WAIT_STATES - 2);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
